mem_writeback: RTL and testbench
================================

Name: mem_writeback

Overview:
- Pipeline stage directly downstream of the load/store unit.
- Tracks the instruction whose address and data were presented to data memory this cycle.
- Selects the memory result (loads) or the ALU result (everything else).
- Delivers a registered register-file write port; flags load-use hazards to decode.
- Preserves a load result across pipeline holds, because the synchronous data memory output is not guaranteed stable while the pipeline is frozen.

Parameters:
- DATA_W, 32, datapath width; must match the memory word width.
- REG_AW, 5, register-index width.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  synchronous, active-high reset.
- hold  input  1  pipeline freeze; upstream holds its inputs while high.
- ex_valid  input  1  instruction present at the load/store stage this cycle.
- ex_is_load  input  1  instruction is a load.
- ex_is_store  input  1  instruction is a store.
- ex_rd  input  REG_AW  destination register index.
- ex_alu_result  input  DATA_W  non-load result (also the effective address for memory ops).
- mem_q  input  DATA_W  data-memory read port; valid the cycle after the address edge.
- dec_rs1  input  REG_AW  decode-stage source register 1.
- dec_rs2  input  REG_AW  decode-stage source register 2.
- wb_we  output  1  register-file write enable.
- wb_rd  output  REG_AW  write index.
- wb_data  output  DATA_W  write data.
- load_use  output  1  combinational hazard flag to decode.

Behaviour:
- Latency: ex_* sampled at edge N into stage A (a_valid, a_load, a_store, a_rd, a_alu). mem_q for that instruction is valid during cycle N..N+1. Stage W registers at edge N+1. wb_* are visible in the cycle after edge N+1, i.e. 2 edges from ex_* to wb_*.
- Stage A update:
  - hold=0: A <= ex_*.
  - hold=1: A retained.
- Stage W update with hold=0:
  - wb_we <= a_valid & ~a_store & (a_rd != 0).
  - wb_rd <= a_rd.
  - wb_data <= a_load ? (cap_valid ? cap_q : mem_q) : a_alu.
- Stage W update with hold=1: wb_we <= 0 (bubble); wb_rd and wb_data retain their values.
- Capture register (cap_q, cap_valid):
  - On an edge with hold=1, a_valid=1, a_load=1, cap_valid=0: cap_q <= mem_q and cap_valid <= 1.
  - Any edge with hold=0 clears cap_valid.
  - Only the first hold cycle is captured; later mem_q changes are ignored.
- FSM (derived from A and capture state):
  - EMPTY: a_valid=0. Go to PEND when a_valid is loaded high.
  - PEND: load pending, not captured.
    - hold=1 with a load pending → HELD.
    - hold=0 → EMPTY or PEND, according to the next ex_valid.
  - HELD: captured.
    - Stays while hold=1.
    - hold=0 → EMPTY or PEND according to ex_valid; the captured value is used for wb_data.
- Stores: never assert wb_we. wb_data takes a_alu; wb_rd takes a_rd.
- rd=0: wb_we is never asserted; wb_data is still updated.
- load_use = a_valid & a_load & (a_rd != 0) & ((dec_rs1 == a_rd) | (dec_rs2 == a_rd)). Purely combinational; it remains asserted through hold.
- ex_is_load and ex_is_store both high: treated as a store (no writeback). Assertion in simulation only.
- Reset: rst dominates hold. Next edge clears every register:
  - wb_we=0, wb_rd=0, wb_data=0, load_use=0.
  - a_*=0, cap_valid=0, cap_q=0, state EMPTY.
  - Any in-flight load is discarded without writeback.

Optional Feature:
- Macro: MEM_WB_STATS_EN.
- Defined: adds outputs retired_loads and retired_stores (each 32 bits, cleared by rst).
  - Each increments by 1 at an edge with hold=0 and a_valid=1 whose instruction is a load or a store respectively.
  - Both wrap from 0xFFFFFFFF to 0.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- ALU op: ex_valid=1, rd=3, alu=0x0000_1234, no hold → two edges later wb_we=1, wb_rd=3, wb_data=0x1234, held for exactly one cycle.
- Load: ex_is_load, rd=5, mem_q=0xDEAD_BEEF in the following cycle → wb_we=1, wb_rd=5, wb_data=0xDEADBEEF two edges after issue.
- Load then hold for 3 cycles, with mem_q changed to 0x0 after the first hold cycle:
  - wb_we=0 during the hold.
  - After release: wb_data=0xDEADBEEF (the captured value), wb_we=1 once.
- Store with rd=7 → wb_we stays 0. Load into rd=0 → wb_we stays 0.
- Load into rd=9 with dec_rs2=9 → load_use=1 in the cycle after issue. dec_rs1=dec_rs2=8 → load_use=0.
- rst asserted while a load is pending and hold=1 → next edge: all outputs 0, no writeback of that load. With MEM_WB_STATS_EN, the counters read 0.

Source files
------------

// File: rtl/mem_writeback.sv
// mem_writeback -- writeback stage directly downstream of the load/store unit.
//
// Tracks the instruction whose address/data reached data memory this cycle
// (stage A). It then picks the memory result for loads or the ALU result for
// everything else, and presents a registered register-file write port (stage W).
// The synchronous data memory output may drift while the pipeline is frozen.
// To cover that, the load result seen on the first hold edge is captured and
// used when the hold releases.
//
// Optional feature: define MEM_WB_STATS_EN to add retired_loads/retired_stores
// counters. When it is undefined, those ports and counters do not exist.
//
// Ports:
//   clk, rst           rising-edge clock, synchronous active-high reset
//   hold               pipeline freeze (upstream holds ex_* while high)
//   ex_valid/ex_is_load/ex_is_store/ex_rd/ex_alu_result
//                      instruction presented to data memory this cycle
//   mem_q              data-memory read data, valid the cycle after the address
//   dec_rs1/dec_rs2    decode-stage source registers (for load_use)
//   wb_we/wb_rd/wb_data registered register-file write port
//   load_use           combinational load-use hazard flag to decode
//   retired_loads/retired_stores (MEM_WB_STATS_EN only) 32-bit retire counters

module mem_writeback #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hold,
  input  logic              ex_valid,
  input  logic              ex_is_load,
  input  logic              ex_is_store,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic [DATA_W-1:0] ex_alu_result,
  input  logic [DATA_W-1:0] mem_q,
  input  logic [REG_AW-1:0] dec_rs1,
  input  logic [REG_AW-1:0] dec_rs2,
  output logic              wb_we,
  output logic [REG_AW-1:0] wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic              load_use
`ifdef MEM_WB_STATS_EN
  ,
  output logic [31:0]       retired_loads,
  output logic [31:0]       retired_stores
`endif
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_PEND  = 2'd1,
    ST_HELD  = 2'd2
  } state_t;

  // Stage A
  logic              a_valid_reg;
  logic              a_load_reg;
  logic              a_store_reg;
  logic [REG_AW-1:0] a_rd_reg;
  logic [DATA_W-1:0] a_alu_reg;

  // Capture register; cap_valid is the HELD state itself
  logic [DATA_W-1:0] cap_q_reg;
  logic              cap_valid;
  logic              capture_en;

  state_t            state_reg;
  state_t            state_next;

  // Stage W
  logic              wb_we_reg;
  logic [REG_AW-1:0] wb_rd_reg;
  logic [DATA_W-1:0] wb_data_reg;

  // A load flagged as a store too is treated as a store everywhere.
  logic a_is_load;
  assign a_is_load = a_load_reg & ~a_store_reg;
  assign cap_valid = (state_reg == ST_HELD);

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_EMPTY;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    capture_en = 1'b0;
    case (state_reg)
      ST_EMPTY: begin
        if (!hold) begin
          state_next = ex_valid ? ST_PEND : ST_EMPTY;
        end
      end
      ST_PEND: begin
        if (hold) begin
          // Only the first hold edge of a pending load grabs mem_q.
          if (a_is_load) begin
            state_next = ST_HELD;
            capture_en = 1'b1;
          end
        end else begin
          state_next = ex_valid ? ST_PEND : ST_EMPTY;
        end
      end
      ST_HELD: begin
        if (!hold) begin
          state_next = ex_valid ? ST_PEND : ST_EMPTY;
        end
      end
      default: begin
        state_next = ST_EMPTY;
      end
    endcase
  end

  // ---------------------------------------------------------------- stage A
  always_ff @(posedge clk) begin
    if (rst) begin
      a_valid_reg <= 1'b0;
      a_load_reg  <= 1'b0;
      a_store_reg <= 1'b0;
      a_rd_reg    <= '0;
      a_alu_reg   <= '0;
    end else if (!hold) begin
      a_valid_reg <= ex_valid;
      a_load_reg  <= ex_is_load;
      a_store_reg <= ex_is_store;
      a_rd_reg    <= ex_rd;
      a_alu_reg   <= ex_alu_result;
    end
  end

  // ---------------------------------------------------------------- capture
  always_ff @(posedge clk) begin
    if (rst) begin
      cap_q_reg <= '0;
    end else if (capture_en) begin
      cap_q_reg <= mem_q;
    end
  end

  // ---------------------------------------------------------------- stage W
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_we_reg   <= 1'b0;
      wb_rd_reg   <= '0;
      wb_data_reg <= '0;
    end else if (hold) begin
      // Bubble: no write, index/data keep their last values.
      wb_we_reg <= 1'b0;
    end else begin
      wb_we_reg   <= a_valid_reg & ~a_store_reg & (a_rd_reg != '0);
      wb_rd_reg   <= a_rd_reg;
      wb_data_reg <= a_is_load ? (cap_valid ? cap_q_reg : mem_q) : a_alu_reg;
    end
  end

  assign wb_we   = wb_we_reg;
  assign wb_rd   = wb_rd_reg;
  assign wb_data = wb_data_reg;

  // ---------------------------------------------------------------- load_use
  logic [REG_AW-1:0] dec_src [2];
  logic [1:0]        src_hit;

  assign dec_src[0] = dec_rs1;
  assign dec_src[1] = dec_rs2;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_src_cmp
      assign src_hit[gi] = (dec_src[gi] == a_rd_reg);
    end
  endgenerate

  // Stays asserted across hold because stage A is retained.
  assign load_use = a_valid_reg & a_is_load & (a_rd_reg != '0) & (|src_hit);

  // ---------------------------------------------------------------- stats
`ifdef MEM_WB_STATS_EN
  logic [31:0] retired_loads_reg;
  logic [31:0] retired_stores_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      retired_loads_reg  <= '0;
      retired_stores_reg <= '0;
    end else if (!hold && a_valid_reg) begin
      if (a_is_load) begin
        retired_loads_reg <= retired_loads_reg + 32'd1;
      end
      if (a_store_reg) begin
        retired_stores_reg <= retired_stores_reg + 32'd1;
      end
    end
  end

  assign retired_loads  = retired_loads_reg;
  assign retired_stores = retired_stores_reg;
`endif

  // ---------------------------------------------------------------- checks
`ifndef SYNTHESIS
  // Load+store together is tolerated (handled as a store) but flagged.
  always @(posedge clk) begin
    if (!rst && !hold && ex_valid) begin
      assert (!(ex_is_load && ex_is_store));
    end
  end
`endif

endmodule

// File: tb/tb_mem_writeback.sv
// tb_mem_writeback -- self-checking bench for mem_writeback.
// The reference model follows each instruction from issue to retirement.
// Each one carries its own result. A load's result is whatever mem_q shows on
// the first edge after issue. The instruction retires on the first edge
// without hold.
module tb_mem_writeback;

  logic        clk;
  logic        rst;
  logic        hold;
  logic        ex_valid;
  logic        ex_is_load;
  logic        ex_is_store;
  logic [4:0]  ex_rd;
  logic [31:0] ex_alu_result;
  logic [31:0] mem_q;
  logic [4:0]  dec_rs1;
  logic [4:0]  dec_rs2;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        load_use;
`ifdef MEM_WB_STATS_EN
  logic [31:0] retired_loads;
  logic [31:0] retired_stores;
`endif

  mem_writeback #(.DATA_W(32), .REG_AW(5)) dut (
    .clk(clk),
    .rst(rst),
    .hold(hold),
    .ex_valid(ex_valid),
    .ex_is_load(ex_is_load),
    .ex_is_store(ex_is_store),
    .ex_rd(ex_rd),
    .ex_alu_result(ex_alu_result),
    .mem_q(mem_q),
    .dec_rs1(dec_rs1),
    .dec_rs2(dec_rs2),
    .wb_we(wb_we),
    .wb_rd(wb_rd),
    .wb_data(wb_data),
    .load_use(load_use)
`ifdef MEM_WB_STATS_EN
    ,
    .retired_loads(retired_loads),
    .retired_stores(retired_stores)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic        valid;
    logic        load;
    logic        store;
    logic [4:0]  rd;
    logic [31:0] alu;
    logic [31:0] data;
    logic        known;
  } instr_t;

  instr_t      inflight[$];
  logic        exp_we;
  logic [4:0]  exp_rd;
  logic [31:0] exp_data;
  logic        exp_lu;
  logic [31:0] exp_loads;
  logic [31:0] exp_stores;
  int          total;
  int          passed;
  int          cyc;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_edge(input bit r, input bit h, input bit v, input bit ld, input bit st,
                            input logic [4:0] rd, input logic [31:0] alu, input logic [31:0] mq);
    instr_t cur;
    instr_t nxt;
    if (r) begin
      inflight.delete();
      inflight.push_back('0);
      exp_we = 0; exp_rd = 0; exp_data = 0;
      exp_loads = 0; exp_stores = 0;
    end else begin
      cur = inflight.pop_front();
      if (!cur.known) begin
        cur.data  = mq;
        cur.known = 1'b1;
      end
      if (h) begin
        inflight.push_front(cur);
        exp_we = 0;
      end else begin
        exp_we   = cur.valid && !cur.store && (cur.rd != 0);
        exp_rd   = cur.rd;
        exp_data = (cur.load && !cur.store) ? cur.data : cur.alu;
        if (cur.valid && cur.load && !cur.store) exp_loads = exp_loads + 1;
        if (cur.valid && cur.store) exp_stores = exp_stores + 1;
        nxt.valid = v; nxt.load = ld; nxt.store = st; nxt.rd = rd;
        nxt.alu = alu; nxt.data = 0; nxt.known = 1'b0;
        inflight.push_back(nxt);
      end
    end
  endtask

  // One cycle: drive inputs, clock an edge, update model, compare.
  task automatic step(input bit r, input bit h, input bit v, input bit ld, input bit st,
                      input logic [4:0] rd, input logic [31:0] alu, input logic [31:0] mq,
                      input logic [4:0] s1, input logic [4:0] s2);
    @(negedge clk);
    rst = r; hold = h; ex_valid = v; ex_is_load = ld; ex_is_store = st;
    ex_rd = rd; ex_alu_result = alu; mem_q = mq; dec_rs1 = s1; dec_rs2 = s2;
    @(posedge clk);
    #1;
    cyc++;
    model_edge(r, h, v, ld, st, rd, alu, mq);
    exp_lu = inflight[0].valid && inflight[0].load && !inflight[0].store &&
             (inflight[0].rd != 0) && ((s1 == inflight[0].rd) || (s2 == inflight[0].rd));
    check("wb_we", wb_we, exp_we);
    check("wb_rd", wb_rd, exp_rd);
    check("wb_data", wb_data, exp_data);
    check("load_use", load_use, exp_lu);
`ifdef MEM_WB_STATS_EN
    check("retired_loads", retired_loads, exp_loads);
    check("retired_stores", retired_stores, exp_stores);
`endif
    $display("cyc %0d rst=%0b hold=%0b v=%0b ld=%0b st=%0b rd=%0d alu=%h mq=%h -> we=%0b rd=%0d data=%h lu=%0b",
             cyc, r, h, v, ld, st, rd, alu, mq, wb_we, wb_rd, wb_data, load_use);
  endtask

  initial begin
    bit r, h, v, ld, st;
    total = 0; passed = 0; cyc = 0;
    rst = 1; hold = 0; ex_valid = 0; ex_is_load = 0; ex_is_store = 0;
    ex_rd = 0; ex_alu_result = 0; mem_q = 0; dec_rs1 = 0; dec_rs2 = 0;

    // Reset state
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("rst_we", wb_we, 0);
    check("rst_data", wb_data, 0);

    // ALU op rd=3
    step(0, 0, 1, 0, 0, 3, 32'h0000_1234, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("alu_we", wb_we, 1);
    check("alu_rd", wb_rd, 3);
    check("alu_data", wb_data, 32'h1234);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("alu_we_once", wb_we, 0);

    // Load rd=5, data arrives the following cycle
    step(0, 0, 1, 1, 0, 5, 32'h100, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 32'hDEAD_BEEF, 0, 0);
    check("ld_we", wb_we, 1);
    check("ld_rd", wb_rd, 5);
    check("ld_data", wb_data, 32'hDEAD_BEEF);

    // Load then 3 hold cycles, mem_q drops to 0 after the first
    step(0, 0, 1, 1, 0, 5, 32'h104, 0, 0, 0);
    step(0, 1, 1, 1, 0, 5, 32'h104, 32'hDEAD_BEEF, 0, 0);
    check("hold1_we", wb_we, 0);
    step(0, 1, 1, 1, 0, 5, 32'h104, 0, 0, 0);
    check("hold2_we", wb_we, 0);
    step(0, 1, 1, 1, 0, 5, 32'h104, 0, 0, 0);
    check("hold3_we", wb_we, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("rel_we", wb_we, 1);
    check("rel_data", wb_data, 32'hDEAD_BEEF);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("rel_we_once", wb_we, 0);

    // Store rd=7, then load into rd=0
    step(0, 0, 1, 0, 1, 7, 32'h55, 0, 0, 0);
    step(0, 0, 1, 1, 0, 0, 32'h66, 0, 0, 0);
    check("st_we", wb_we, 0);
    check("st_data", wb_data, 32'h55);
    step(0, 0, 0, 0, 0, 0, 0, 32'hABC, 0, 0);
    check("rd0_we", wb_we, 0);
    check("rd0_data", wb_data, 32'hABC);

    // Load-use hazard, persistence through hold, then reset mid-hold
    step(0, 0, 1, 1, 0, 9, 32'h200, 0, 1, 9);
    check("lu_hit", load_use, 1);
    step(0, 1, 1, 1, 0, 9, 32'h200, 32'h1111, 8, 8);
    check("lu_miss", load_use, 0);
    step(0, 1, 1, 1, 0, 9, 32'h200, 32'h2222, 9, 0);
    check("lu_hold", load_use, 1);
    step(1, 1, 1, 1, 0, 9, 32'h200, 32'h3333, 9, 9);
    check("rst_mid_we", wb_we, 0);
    check("rst_mid_lu", load_use, 0);
    check("rst_mid_rd", wb_rd, 0);
`ifdef MEM_WB_STATS_EN
    check("rst_mid_loads", retired_loads, 0);
`endif
    step(0, 0, 0, 0, 0, 0, 0, 32'h4444, 9, 9);
    check("rst_no_wb", wb_we, 0);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      r  = ($urandom_range(0, 49) == 0);
      h  = ($urandom_range(0, 9) < 3);
      v  = $urandom_range(0, 1);
      ld = v && $urandom_range(0, 1);
      st = v && !ld && $urandom_range(0, 1);
      step(r, h, v, ld, st, 5'($urandom_range(0, 3)), $urandom, $urandom,
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
